kamus_l1d_dmem: RTL
===================

// Module: kamus_l1d_dmem
// PURPOSE
//  Responder end of the core's $L1D interface: single-port word array plus a posted-write buffer.
//  Sits below kamus_MEM. Loads are answered combinationally in the same cycle. Stores are
//  accepted into a FIFO and drained into the array in cycles with no load.
//  Byte enables support SB/SH; the LSU supplies aligned lane data.
// PARAMETERS
//  DEPTH     1024  array size in 32-bit words; power of 2; IDX_W = $clog2(DEPTH)
//  WB_DEPTH  4     write-buffer entries; power of 2, >= 2
// PORTS
//  clk_i          in   1   clock; all state updates on rising edge
//  rst_ni         in   1   reset; synchronous, active-low
//  l1d_rd_en_i    in   1   load request this cycle
//  l1d_wr_en_i    in   1   store request this cycle
//  l1d_addr_i     in   32  byte address; [1:0] ignored, word index = [IDX_W+1:2]
//  l1d_wr_data_i  in   32  store data, already lane-aligned
//  l1d_wr_be_i    in   4   byte enables; bit n selects data[8n+7:8n]
//  l1d_rd_data_o  out  32  load data, combinational
//  l1d_stall_o    out  1   request not taken this cycle; requester must hold its request
//  l1d_err_o      out  1   registered 1-cycle pulse: out-of-range access was accepted
//  l1d_drained_o  out  1   write buffer empty (used by fence)
// BEHAVIOUR
//  Reset (rst_ni=0 at an edge):
//   - FIFO count, head and tail are set to 0; pending stores are discarded.
//   - l1d_err_o=0. Array contents are not reset.
//   - After reset: stall_o=0 and drained_o=1. rd_data_o=0 whenever rd_en_i=0.
//  Range check: the access is in range iff addr[31:IDX_W+2]==0.
//   - Out-of-range load returns 0. Out-of-range store is dropped, not buffered.
//   - Either case, when accepted, sets err_o=1 for the next cycle.
//  Store:
//   - Accepted when wr_en_i=1 and the FIFO is not full (count<WB_DEPTH).
//   - An accepted store pushes {idx, data, be} at the tail on that edge.
//   - When full, stall_o=1 and the store is ignored; the full check uses count only.
//   - be=4'b0000 is accepted and pushed, with no array effect.
//  Drain:
//   - Occurs when count>0 and the array port is free: rd_en_i=0, or the load is stalled (no-forward hazard).
//   - Writes the head entry into the array under its be, then pops.
//   - Push and pop in the same cycle: count is unchanged; pointers wrap modulo WB_DEPTH.
//  Load:
//   - rd_data_o = array[idx], with pending FIFO entries matching idx merged per byte
//     (oldest to youngest; youngest wins).
//   - A store accepted in the same cycle is invisible to that load; it is visible from the next cycle.
//  Load and store in the same cycle: both are serviced; drain is suppressed.
//  Latency: load 0 cycles; store to array >= 1 cycle after acceptance; drained_o = (count==0).
// CONFIGURATION
//  KAMUS_L1D_FWD_EN defined:
//   - Store-to-load forwarding by byte merge, as above; loads never stall.
//  KAMUS_L1D_FWD_EN undefined:
//   - A load whose idx matches any FIFO entry gets stall_o=1 and rd_data_o=0.
//   - The FIFO keeps draining (guarantees progress); the load completes once no entry matches.
//   - A store arriving in a stalled cycle is also not accepted.
// STRUCTURE
//  kamus_pkg:
//   - typedef l1d_wb_entry_t {logic [IDX_W-1:0] idx; logic [31:0] data; logic [3:0] be;}
//   - L1D_DEPTH and L1D_WB_DEPTH defaults.
//  Sub-module kamus_l1d_wbuf:
//   - Parameterised FIFO; push/pop/count/full.
//   - Exposes all entries plus valid bits for the match/merge logic.
//  Top level: the array, range check, merge/forward mux, drain arbitration, err register.
// TESTING
//  1. Store 0xDEADBEEF, be=F, at 0x10; load 0x10 next cycle -> 0xDEADBEEF
//     (fwd build: 0 stall; no-fwd build: stall until drained).
//  2. Store 0x000000AA be=0001, then 0x0000BB00 be=0010, to 0x20 (array word was 0x11223344);
//     fwd load -> 0x1122BBAA.
//  3. Four back-to-back stores with rd_en_i held 1 -> stall_o=1 on the 5th; drop rd_en_i
//     -> one pop per cycle; drained_o=1 after 4 cycles.
//  4. Load at 0x4000_0000 with DEPTH=1024 -> rd_data_o=0, err_o=1 the next cycle;
//     store at the same address -> no FIFO push, err_o pulse.
//  5. Fill the FIFO with 3 entries, assert rst_ni=0 for 1 cycle -> drained_o=1,
//     array unchanged at those addresses.
//  6. Load and store to the same address in the same cycle: load returns the old data;
//     a load the next cycle returns the new data.

Source files
------------

// File: rtl/kamus_pkg.sv
// rtl/kamus_pkg.sv - shared types and defaults for the kamus L1D data memory
package kamus_pkg;

    localparam int L1D_DEPTH    = 1024;
    localparam int L1D_WB_DEPTH = 4;
    localparam int L1D_IDX_W    = $clog2(L1D_DEPTH);

    // One posted store. The idx field is sized for the default array depth;
    // smaller arrays zero-extend their word index into it.
    typedef struct packed {
        logic [L1D_IDX_W-1:0] idx;
        logic [31:0]          data;
        logic [3:0]           be;
    } l1d_wb_entry_t;

    // Overlay the enabled byte lanes of data onto base.
    function automatic logic [31:0] l1d_merge_bytes(input logic [31:0] base,
                                                    input logic [31:0] data,
                                                    input logic [3:0]  be);
        logic [31:0] res;
        res = base;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) res[8*b +: 8] = data[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/kamus_l1d_wbuf.sv
// rtl/kamus_l1d_wbuf.sv - posted-write FIFO exposing all entries oldest-first
//
// Ports:
//   clk_i, rst_ni   clock, synchronous active-low reset (clears pointers and count)
//   push_i          enqueue push_entry_i at the tail (ignored when full)
//   push_entry_i    entry to enqueue
//   pop_i           dequeue the head entry (ignored when empty)
//   full_o          count == DEPTH
//   count_o         number of valid entries
//   entries_o[k]    k-th oldest entry (entries_o[0] is the head)
//   valid_o[k]      entries_o[k] holds a pending store
module kamus_l1d_wbuf
    import kamus_pkg::*;
#(
    parameter int  DEPTH = L1D_WB_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 push_i,
    input  l1d_wb_entry_t        push_entry_i,
    input  logic                 pop_i,
    output logic                 full_o,
    output logic [CNT_W-1:0]     count_o,
    output l1d_wb_entry_t        entries_o [DEPTH],
    output logic                 valid_o   [DEPTH]
);

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    l1d_wb_entry_t    slots [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count == CNT_W'(DEPTH));
    assign count_o = count;
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && (count != '0);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) slots[wr_ptr] <= push_entry_i;
    end

    // Present entries in age order so the merge logic can apply them
    // oldest to youngest without knowing the pointer positions.
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            entries_o[k] = slots[rd_ptr + PTR_W'(k)];
            valid_o[k]   = (CNT_W'(k) < count);
        end
    end

endmodule

// File: rtl/kamus_l1d_dmem.sv
// rtl/kamus_l1d_dmem.sv - L1D responder: word array with posted-write buffer
//
// Build option: KAMUS_L1D_FWD_EN enables store-to-load byte forwarding from the
// write buffer; without it a load hitting a pending store stalls until drained.
//
// Ports:
//   clk_i, rst_ni    clock, synchronous active-low reset
//   l1d_rd_en_i      load request
//   l1d_wr_en_i      store request
//   l1d_addr_i       byte address; word index = addr[IDX_W+1:2]
//   l1d_wr_data_i    lane-aligned store data
//   l1d_wr_be_i      store byte enables
//   l1d_rd_data_o    combinational load data (0 when no load is served)
//   l1d_stall_o      request not taken; requester holds it
//   l1d_err_o        one-cycle pulse after an accepted out-of-range access
//   l1d_drained_o    write buffer empty
module kamus_l1d_dmem
    import kamus_pkg::*;
#(
    parameter int  DEPTH    = L1D_DEPTH,
    parameter int  WB_DEPTH = L1D_WB_DEPTH,
    localparam int IDX_W    = $clog2(DEPTH),
    localparam int CNT_W    = $clog2(WB_DEPTH) + 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        l1d_rd_en_i,
    input  logic        l1d_wr_en_i,
    input  logic [31:0] l1d_addr_i,
    input  logic [31:0] l1d_wr_data_i,
    input  logic [3:0]  l1d_wr_be_i,
    output logic [31:0] l1d_rd_data_o,
    output logic        l1d_stall_o,
    output logic        l1d_err_o,
    output logic        l1d_drained_o
);

    logic [31:0]          mem [DEPTH];
    logic [IDX_W-1:0]     idx;
    logic [L1D_IDX_W-1:0] idx_key;
    logic                 in_range;
    logic                 unused_addr_lsb;

    logic                 wb_full;
    logic [CNT_W-1:0]     wb_count;
    l1d_wb_entry_t        wb_entries [WB_DEPTH];
    logic                 wb_valid   [WB_DEPTH];
    l1d_wb_entry_t        push_entry;

    logic                 ld_hazard;
    logic                 ld_served;
    logic                 st_accept;
    logic                 wb_push;
    logic                 drain;
    logic [31:0]          merged;
    logic                 err_q;

    assign idx             = l1d_addr_i[IDX_W+1:2];
    assign idx_key         = L1D_IDX_W'(idx);
    assign in_range        = (l1d_addr_i[31:IDX_W+2] == '0);
    assign unused_addr_lsb = ^l1d_addr_i[1:0];

`ifdef KAMUS_L1D_FWD_EN
    assign ld_hazard = 1'b0;

    // Byte-merge pending stores over the array word, youngest last so it wins.
    always_comb begin
        merged = mem[idx];
        for (int k = 0; k < WB_DEPTH; k++) begin
            if (wb_valid[k] && (wb_entries[k].idx == idx_key)) begin
                merged = l1d_merge_bytes(merged, wb_entries[k].data, wb_entries[k].be);
            end
        end
    end
`else
    logic ld_match;

    always_comb begin
        ld_match = 1'b0;
        for (int k = 0; k < WB_DEPTH; k++) begin
            if (wb_valid[k] && (wb_entries[k].idx == idx_key)) ld_match = 1'b1;
        end
    end

    // Out-of-range loads never touch the array, so they cannot hazard.
    assign ld_hazard = l1d_rd_en_i && in_range && ld_match;
    assign merged    = mem[idx];
`endif

    // A hazard-stalled cycle takes neither request; the full check alone
    // only holds back the store.
    assign ld_served = l1d_rd_en_i && !ld_hazard;
    assign st_accept = l1d_wr_en_i && !wb_full && !ld_hazard;
    assign wb_push   = st_accept && in_range;
    // The array port is free when no load uses it; a hazard-stalled load
    // yields the port so the matching entry can drain.
    assign drain     = (wb_count != '0) && (!l1d_rd_en_i || ld_hazard);

    assign l1d_stall_o   = ld_hazard || (l1d_wr_en_i && wb_full);
    assign l1d_rd_data_o = (ld_served && in_range) ? merged : 32'h0;
    assign l1d_drained_o = (wb_count == '0);
    assign l1d_err_o     = err_q;

    assign push_entry.idx  = idx_key;
    assign push_entry.data = l1d_wr_data_i;
    assign push_entry.be   = l1d_wr_be_i;

    kamus_l1d_wbuf #(
        .DEPTH (WB_DEPTH)
    ) u_wbuf (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .push_i       (wb_push),
        .push_entry_i (push_entry),
        .pop_i        (drain),
        .full_o       (wb_full),
        .count_o      (wb_count),
        .entries_o    (wb_entries),
        .valid_o      (wb_valid)
    );

    // Reset discards pending stores, so no drain write may land on a reset edge.
    always_ff @(posedge clk_i) begin
        if (rst_ni && drain) begin
            mem[wb_entries[0].idx[IDX_W-1:0]] <=
                l1d_merge_bytes(mem[wb_entries[0].idx[IDX_W-1:0]],
                                wb_entries[0].data, wb_entries[0].be);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else begin
            err_q <= (ld_served || st_accept) && !in_range;
        end
    end

endmodule
